// File: rtl/bram32_arbiter.sv
// Shares one 32-bit block-RAM port between an instruction fetch bus and a data bus.
// Handles round-robin arbitration, sub-word write encoding and load-data alignment and extension.
module bram32_arbiter #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int AW         = ADDR_WIDTH + 2
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ibus_req,
  input  logic [AW-1:0]         i_ibus_addr,
  output logic                  o_ibus_gnt,
  output logic                  o_ibus_rvalid,
  output logic [31:0]           o_ibus_rdata,
  input  logic                  i_dbus_req,
  input  logic                  i_dbus_we,
  input  logic [AW-1:0]         i_dbus_addr,
  input  logic [1:0]            i_dbus_size,
  input  logic                  i_dbus_unsigned,
  input  logic [31:0]           i_dbus_wdata,
  output logic                  o_dbus_gnt,
  output logic                  o_dbus_rvalid,
  output logic [31:0]           o_dbus_rdata,
  output logic                  o_dbus_err,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [31:0]           o_mem_wdata,
  output logic                  o_mem_we,
  output logic [2:0]            o_mem_wr_subaddr,
  input  logic [31:0]           i_mem_rdata
);

  typedef enum logic {PTR_IBUS, PTR_DBUS} ptr_e;

  ptr_e       last_q, last_d;
  logic       ibus_gnt, dbus_gnt;
  logic       dbus_legal;
  logic [2:0] dbus_code;

  logic       ivalid_q, dvalid_q;
  logic [1:0] off_q, size_q;
  logic       uns_q, we_q, err_q;

  logic       ivalid, dvalid;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  // On a tie the port that was not granted last wins.
  always_comb begin
    ibus_gnt = 1'b0;
    dbus_gnt = 1'b0;
    if (!i_rst) begin
      if (i_ibus_req && i_dbus_req) begin
        if (last_q == PTR_IBUS) dbus_gnt = 1'b1;
        else                    ibus_gnt = 1'b1;
      end else begin
        ibus_gnt = i_ibus_req;
        dbus_gnt = i_dbus_req;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (ibus_gnt)      last_d = PTR_IBUS;
    else if (dbus_gnt) last_d = PTR_DBUS;
  end

  always_comb begin
    dbus_legal = 1'b0;
    dbus_code  = 3'd0;
    case (i_dbus_size)
      2'd0: begin dbus_legal = 1'b1;                      dbus_code = {1'b1, i_dbus_addr[1:0]}; end
      2'd1: begin dbus_legal = ~i_dbus_addr[0];           dbus_code = {2'b01, i_dbus_addr[1]};  end
      2'd2: begin dbus_legal = (i_dbus_addr[1:0] == 2'd0); dbus_code = 3'd1;                     end
      default: begin dbus_legal = 1'b0;                   dbus_code = 3'd0;                     end
    endcase
  end

  assign o_ibus_gnt       = ibus_gnt;
  assign o_dbus_gnt       = dbus_gnt;
  assign o_mem_addr       = dbus_gnt ? i_dbus_addr[AW-1:2] : i_ibus_addr[AW-1:2];
  assign o_mem_wdata      = i_dbus_wdata;
  assign o_mem_we         = dbus_gnt & i_dbus_we & dbus_legal;
  assign o_mem_wr_subaddr = o_mem_we ? dbus_code : 3'd0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      last_q   <= PTR_IBUS;
      ivalid_q <= 1'b0;
      dvalid_q <= 1'b0;
      off_q    <= 2'd0;
      size_q   <= 2'd0;
      uns_q    <= 1'b0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      last_q   <= last_d;
      ivalid_q <= ibus_gnt;
      dvalid_q <= dbus_gnt;
      if (dbus_gnt) begin
        off_q  <= i_dbus_addr[1:0];
        size_q <= i_dbus_size;
        uns_q  <= i_dbus_unsigned;
        we_q   <= i_dbus_we;
        err_q  <= ~dbus_legal;
      end
    end
  end

  // A reset landing in the response cycle suppresses the pending response.
  assign ivalid = ivalid_q & ~i_rst;
  assign dvalid = dvalid_q & ~i_rst;

  always_comb begin
    rd_byte = i_mem_rdata[{off_q, 3'b000} +: 8];
    rd_half = i_mem_rdata[{off_q[1], 4'b0000} +: 16];
    case (size_q)
      2'd0:    rd_ext = {{24{~uns_q & rd_byte[7]}}, rd_byte};
      2'd1:    rd_ext = {{16{~uns_q & rd_half[15]}}, rd_half};
      default: rd_ext = i_mem_rdata;
    endcase
  end

  assign o_ibus_rvalid = ivalid;
  assign o_ibus_rdata  = ivalid ? i_mem_rdata : 32'd0;
  assign o_dbus_rvalid = dvalid;
  assign o_dbus_err    = dvalid & err_q;
  assign o_dbus_rdata  = (dvalid && !we_q && !err_q) ? rd_ext : 32'd0;

endmodule
